// File: rtl/exec_alu_pkg.sv
// Shared constants for the execute-stage ALU: alu_op classes, ALU control
// codes and R-type funct values.
package exec_alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] ALUOP_ADD  = 3'b000;
  localparam logic [2:0] ALUOP_SUB  = 3'b001;
  localparam logic [2:0] ALUOP_RTYP = 3'b010;
  localparam logic [2:0] ALUOP_AND  = 3'b011;
  localparam logic [2:0] ALUOP_OR   = 3'b100;
  localparam logic [2:0] ALUOP_SLT  = 3'b101;
  localparam logic [2:0] ALUOP_LUI  = 3'b110;
  localparam logic [2:0] ALUOP_XOR  = 3'b111;

  localparam logic [3:0] ALUC_AND  = 4'b0000;
  localparam logic [3:0] ALUC_OR   = 4'b0001;
  localparam logic [3:0] ALUC_ADD  = 4'b0010;
  localparam logic [3:0] ALUC_XOR  = 4'b0011;
  localparam logic [3:0] ALUC_SUB  = 4'b0110;
  localparam logic [3:0] ALUC_SLT  = 4'b0111;
  localparam logic [3:0] ALUC_SLL  = 4'b1000;
  localparam logic [3:0] ALUC_SRL  = 4'b1001;
  localparam logic [3:0] ALUC_SRA  = 4'b1010;
  localparam logic [3:0] ALUC_SLTU = 4'b1011;
  localparam logic [3:0] ALUC_NOR  = 4'b1100;
  localparam logic [3:0] ALUC_LUI  = 4'b1101;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_JR   = 6'h08;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU = 6'h2B;

endpackage

// File: rtl/exec_alu_ctrl_decode.sv
// Combinational ALU-control decode: alu_op class plus funct field to a
// 4-bit ALU control code and the jump-register flag.
module exec_alu_ctrl_decode
  import exec_alu_pkg::*;
(
  input  logic [2:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ctrl_o,
  output logic       jr_o
);

  always_comb begin
    alu_ctrl_o = ALUC_ADD;
    jr_o       = 1'b0;
    case (alu_op_i)
      ALUOP_ADD: alu_ctrl_o = ALUC_ADD;
      ALUOP_SUB: alu_ctrl_o = ALUC_SUB;
      ALUOP_AND: alu_ctrl_o = ALUC_AND;
      ALUOP_OR:  alu_ctrl_o = ALUC_OR;
      ALUOP_SLT: alu_ctrl_o = ALUC_SLT;
      ALUOP_LUI: alu_ctrl_o = ALUC_LUI;
      ALUOP_XOR: alu_ctrl_o = ALUC_XOR;
      ALUOP_RTYP: begin
        // Unrecognised functs fall back to ADD so the datapath stays defined
        case (funct_i)
          FUNCT_ADD, FUNCT_ADDU: alu_ctrl_o = ALUC_ADD;
          FUNCT_SUB, FUNCT_SUBU: alu_ctrl_o = ALUC_SUB;
          FUNCT_AND:  alu_ctrl_o = ALUC_AND;
          FUNCT_OR:   alu_ctrl_o = ALUC_OR;
          FUNCT_XOR:  alu_ctrl_o = ALUC_XOR;
          FUNCT_NOR:  alu_ctrl_o = ALUC_NOR;
          FUNCT_SLT:  alu_ctrl_o = ALUC_SLT;
          FUNCT_SLTU: alu_ctrl_o = ALUC_SLTU;
          FUNCT_SLL:  alu_ctrl_o = ALUC_SLL;
          FUNCT_SRL:  alu_ctrl_o = ALUC_SRL;
          FUNCT_SRA:  alu_ctrl_o = ALUC_SRA;
          FUNCT_JR: begin
            alu_ctrl_o = ALUC_ADD;
            jr_o       = 1'b1;
          end
          default:    alu_ctrl_o = ALUC_ADD;
        endcase
      end
      default: alu_ctrl_o = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/exec_alu_unit.sv
// Execute-stage ALU with control decode, branch-target adder and a single
// registered output stage that holds while in_valid is low.
module exec_alu_unit
  import exec_alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            in_valid,
  input  logic [2:0]      alu_op,
  input  logic [5:0]      funct,
  input  logic [4:0]      shamt,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] imm_ext,
  output logic            out_valid,
  output logic [XLEN-1:0] alu_result,
  output logic            zero,
  output logic [3:0]      alu_ctrl,
  output logic            jr_signal,
  output logic [XLEN-1:0] branch_target
);

  logic [3:0]      alu_ctrl_d;
  logic            jr_d;
  logic [XLEN-1:0] alu_result_d;
  logic [XLEN-1:0] branch_target_d;

  logic            out_valid_q;
  logic [XLEN-1:0] alu_result_q;
  logic            zero_q;
  logic [3:0]      alu_ctrl_q;
  logic            jr_q;
  logic [XLEN-1:0] branch_target_q;

  exec_alu_ctrl_decode u_ctrl_decode (
    .alu_op_i   (alu_op),
    .funct_i    (funct),
    .alu_ctrl_o (alu_ctrl_d),
    .jr_o       (jr_d)
  );

  // Shifts act on operand_b by shamt; operand_a is not involved.
  always_comb begin
    alu_result_d = '0;
    case (alu_ctrl_d)
      ALUC_AND:  alu_result_d = operand_a & operand_b;
      ALUC_OR:   alu_result_d = operand_a | operand_b;
      ALUC_ADD:  alu_result_d = operand_a + operand_b;
      ALUC_XOR:  alu_result_d = operand_a ^ operand_b;
      ALUC_SUB:  alu_result_d = operand_a - operand_b;
      ALUC_SLT:  alu_result_d = {{(XLEN-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      ALUC_SLTU: alu_result_d = {{(XLEN-1){1'b0}}, (operand_a < operand_b)};
      ALUC_SLL:  alu_result_d = operand_b << shamt;
      ALUC_SRL:  alu_result_d = operand_b >> shamt;
      ALUC_SRA:  alu_result_d = $unsigned($signed(operand_b) >>> shamt);
      ALUC_NOR:  alu_result_d = ~(operand_a | operand_b);
      ALUC_LUI:  alu_result_d = operand_b << 16;
      default:   alu_result_d = '0;
    endcase
  end

  // The shift drops imm_ext's top two bits; the sum wraps modulo 2^XLEN.
  assign branch_target_d = pc_plus4 + (imm_ext << 2);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      out_valid_q     <= 1'b0;
      alu_result_q    <= '0;
      zero_q          <= 1'b0;
      alu_ctrl_q      <= '0;
      jr_q            <= 1'b0;
      branch_target_q <= '0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        alu_result_q    <= alu_result_d;
        zero_q          <= (alu_result_d == '0);
        alu_ctrl_q      <= alu_ctrl_d;
        jr_q            <= jr_d;
        branch_target_q <= branch_target_d;
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign alu_result    = alu_result_q;
  assign zero          = zero_q;
  assign alu_ctrl      = alu_ctrl_q;
  assign jr_signal     = jr_q;
  assign branch_target = branch_target_q;

endmodule

// File: tb/tb_exec_alu_unit.sv
// Randomized and directed checks of exec_alu_unit against an instruction-level
// reference model.
module tb_exec_alu_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        in_valid;
  logic [2:0]  alu_op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] operand_a, operand_b, pc_plus4, imm_ext;
  logic        out_valid;
  logic [31:0] alu_result;
  logic        zero;
  logic [3:0]  alu_ctrl;
  logic        jr_signal;
  logic [31:0] branch_target;

  int n_checks = 0;
  int n_errors = 0;

  logic        exp_valid;
  logic [31:0] exp_res;
  logic        exp_zero;
  logic [3:0]  exp_ctrl;
  logic        exp_jr;
  logic [31:0] exp_bt;

  exec_alu_unit dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .in_valid      (in_valid),
    .alu_op        (alu_op),
    .funct         (funct),
    .shamt         (shamt),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .pc_plus4      (pc_plus4),
    .imm_ext       (imm_ext),
    .out_valid     (out_valid),
    .alu_result    (alu_result),
    .zero          (zero),
    .alu_ctrl      (alu_ctrl),
    .jr_signal     (jr_signal),
    .branch_target (branch_target)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Instruction semantics taken straight from the opcode/funct tables.
  task automatic model(output logic [31:0] res, output logic [3:0] ctrl, output logic jr);
    logic signed [31:0] sa, sb;
    sa = operand_a;
    sb = operand_b;
    res = 32'h0; ctrl = 4'b0010; jr = 1'b0;
    case (alu_op)
      3'b000: begin res = operand_a + operand_b; ctrl = 4'b0010; end
      3'b001: begin res = operand_a - operand_b; ctrl = 4'b0110; end
      3'b011: begin res = operand_a & operand_b; ctrl = 4'b0000; end
      3'b100: begin res = operand_a | operand_b; ctrl = 4'b0001; end
      3'b101: begin res = (sa < sb) ? 32'd1 : 32'd0; ctrl = 4'b0111; end
      3'b110: begin res = {operand_b[15:0], 16'h0000}; ctrl = 4'b1101; end
      3'b111: begin res = operand_a ^ operand_b; ctrl = 4'b0011; end
      default: begin
        case (funct)
          6'h20, 6'h21: begin res = operand_a + operand_b; ctrl = 4'b0010; end
          6'h22, 6'h23: begin res = operand_a - operand_b; ctrl = 4'b0110; end
          6'h24: begin res = operand_a & operand_b; ctrl = 4'b0000; end
          6'h25: begin res = operand_a | operand_b; ctrl = 4'b0001; end
          6'h26: begin res = operand_a ^ operand_b; ctrl = 4'b0011; end
          6'h27: begin res = ~(operand_a | operand_b); ctrl = 4'b1100; end
          6'h2A: begin res = (sa < sb) ? 32'd1 : 32'd0; ctrl = 4'b0111; end
          6'h2B: begin res = (operand_a < operand_b) ? 32'd1 : 32'd0; ctrl = 4'b1011; end
          6'h00: begin res = operand_b * (32'd1 << shamt); ctrl = 4'b1000; end
          6'h02: begin res = operand_b / (33'd1 << shamt); ctrl = 4'b1001; end
          6'h03: begin res = $unsigned(sb >>> shamt); ctrl = 4'b1010; end
          6'h08: begin res = operand_a + operand_b; ctrl = 4'b0010; jr = 1'b1; end
          default: begin res = operand_a + operand_b; ctrl = 4'b0010; end
        endcase
      end
    endcase
  endtask

  // Clock one edge, advance the expected output registers, compare all outputs.
  task automatic cycle(input string tag);
    logic [31:0] r;
    logic [3:0]  c;
    logic        j;
    model(r, c, j);
    @(posedge Clock);
    #1;
    if (Reset) begin
      exp_valid = 0; exp_res = 0; exp_zero = 0; exp_ctrl = 0; exp_jr = 0; exp_bt = 0;
    end else begin
      exp_valid = in_valid;
      if (in_valid) begin
        exp_res  = r;
        exp_zero = (r == 32'h0);
        exp_ctrl = c;
        exp_jr   = j;
        exp_bt   = pc_plus4 + {imm_ext[29:0], 2'b00};
      end
    end
    chk({tag, ".valid"}, {31'h0, out_valid}, {31'h0, exp_valid});
    chk({tag, ".result"}, alu_result, exp_res);
    chk({tag, ".zero"}, {31'h0, zero}, {31'h0, exp_zero});
    chk({tag, ".ctrl"}, {28'h0, alu_ctrl}, {28'h0, exp_ctrl});
    chk({tag, ".jr"}, {31'h0, jr_signal}, {31'h0, exp_jr});
    chk({tag, ".btarget"}, branch_target, exp_bt);
  endtask

  task automatic drive(input logic [2:0] op, input logic [5:0] f, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; alu_op = op; funct = f; shamt = sh; operand_a = a; operand_b = b;
  endtask

  logic [5:0] funct_list [14];

  initial begin
    funct_list = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                   6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08};
    Reset = 1'b1; in_valid = 1'b1; alu_op = 3'b010; funct = 6'h20; shamt = 5'd3;
    operand_a = $urandom; operand_b = $urandom; pc_plus4 = $urandom; imm_ext = $urandom;
    cycle("reset0");
    cycle("reset1");
    chk("reset.zero_low", {31'h0, zero}, 32'h0);
    Reset = 1'b0;
    pc_plus4 = 32'h0040_0008; imm_ext = 32'hFFFF_FFFE;

    drive(3'b010, 6'h20, 0, 32'h7FFF_FFFF, 32'h1);
    cycle("add_ovf");
    chk("add_ovf.const", alu_result, 32'h8000_0000);
    chk("bt_neg.const", branch_target, 32'h0040_0000);

    drive(3'b001, 6'h3F, 0, 32'h1234, 32'h1234);
    imm_ext = 32'h3;
    cycle("sub_zero");
    chk("sub_zero.const", {31'h0, zero}, 32'h1);
    chk("bt_pos.const", branch_target, 32'h0040_0014);

    drive(3'b010, 6'h2A, 0, 32'hFFFF_FFFF, 32'h1);
    cycle("slt");
    chk("slt.const", alu_result, 32'h1);
    drive(3'b010, 6'h2B, 0, 32'hFFFF_FFFF, 32'h1);
    cycle("sltu");
    chk("sltu.const", alu_result, 32'h0);

    drive(3'b010, 6'h00, 4, $urandom, 32'h8000_0010);
    cycle("sll");
    chk("sll.const", alu_result, 32'h0000_0100);
    drive(3'b010, 6'h02, 4, $urandom, 32'h8000_0010);
    cycle("srl");
    chk("srl.const", alu_result, 32'h0800_0001);
    drive(3'b010, 6'h03, 4, $urandom, 32'h8000_0010);
    cycle("sra");
    chk("sra.const", alu_result, 32'hF800_0001);
    drive(3'b010, 6'h03, 0, $urandom, 32'h8000_0010);
    cycle("sra0");
    chk("sra0.const", alu_result, 32'h8000_0010);

    drive(3'b010, 6'h08, 0, 32'h0040_0020, 32'h0);
    pc_plus4 = 32'hFFFF_FFFC; imm_ext = 32'h2;
    cycle("jr");
    chk("jr.const", {31'h0, jr_signal}, 32'h1);
    chk("jr_res.const", alu_result, 32'h0040_0020);
    chk("bt_wrap.const", branch_target, 32'h0000_0004);
    drive(3'b010, 6'h3F, 0, 32'h5, 32'h7);
    cycle("unk_funct");
    chk("unk.const", alu_result, 32'hC);

    drive(3'b110, 6'h00, 0, 32'h0, 32'hDEAD_BEEF);
    cycle("lui");
    chk("lui.const", alu_result, 32'hBEEF_0000);

    in_valid = 1'b0; operand_a = $urandom; operand_b = $urandom; pc_plus4 = $urandom;
    cycle("hold");
    chk("hold.const", alu_result, 32'hBEEF_0000);

    for (int i = 0; i < 400; i++) begin
      Reset     = ($urandom_range(0, 49) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      alu_op    = 3'($urandom_range(0, 7));
      funct     = ($urandom_range(0, 4) == 0) ? 6'($urandom) : funct_list[$urandom_range(0, 13)];
      shamt     = 5'($urandom);
      operand_a = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      operand_b = ($urandom_range(0, 7) == 0) ? operand_a : $urandom;
      pc_plus4  = $urandom;
      imm_ext   = $urandom;
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
